// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter for 16 requesters sharing a 16:1 select datapath.
// Produces a registered one-hot grant plus matching 4-bit mux select with hold-time limiting.
module mux16_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        rel,
    output logic [15:0] gnt,
    output logic [3:0]  sel,
    output logic        busy,
    output logic        timeout
);

    localparam int unsigned N  = 16;
    localparam int unsigned SW = 4;
    localparam int unsigned CW = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state;
    logic [SW-1:0] ptr;
    logic [CW-1:0] hold_cnt;

    logic [SW-1:0] pick;
    logic [SW-1:0] idx;
    logic          found;
    logic          hold_hit;
    logic          release_now;

    // First requester at or after ptr, scanning upward with 4-bit wrap.
    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            idx = ptr + SW'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // MAX_HOLD of zero disables the limit entirely.
    always_comb begin
        hold_hit    = (MAX_HOLD != 0) && (hold_cnt == CW'(MAX_HOLD - 1));
        release_now = rel || !req[sel] || hold_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            sel      <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt      <= N'(1) << pick;
                        sel      <= pick;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + CW'(1);
                    end
                    if (release_now) begin
                        gnt     <= '0;
                        busy    <= 1'b0;
                        ptr     <= sel + SW'(1);
                        state   <= IDLE;
                        // Only flag revocation when the owner still wanted the bus.
                        timeout <= !rel && req[sel];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed bench for mux16_rr_arbiter (MAX_HOLD=4): per-cycle vector table plus
// a hand-written hold-limit sequence, with grant invariants checked every cycle.
module tb_mux16_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        rel;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        busy;
    logic        timeout;

    int tests;
    int fails;
    int step_no;

    mux16_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .rel    (rel),
        .gnt    (gnt),
        .sel    (sel),
        .busy   (busy),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [15:0] q;
        logic        l;
        logic [15:0] e_gnt;
        logic [3:0]  e_sel;
        logic        e_busy;
        logic        e_to;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic [15:0] q, input logic l,
                                input logic [15:0] g, input logic [3:0] s,
                                input logic b, input logic t);
        vec_t v;
        v.r = r; v.q = q; v.l = l;
        v.e_gnt = g; v.e_sel = s; v.e_busy = b; v.e_to = t;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %h expected %h", name, step_no, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [15:0] q, input logic l);
        @(negedge clk);
        rst = r;
        req = q;
        rel = l;
        @(posedge clk);
        #1;
        step_no++;
    endtask

    task automatic check_inv();
        logic [15:0] g;
        g = gnt;
        chk("onehot0", 16'(g & (g - 16'd1)), 16'h0000);
        chk("busy_or", 16'(busy), 16'(|g));
        if (busy) chk("gnt_sel", 16'(g[sel]), 16'h0001);
    endtask

    initial begin
        tests = 0; fails = 0; step_no = 0;
        rst = 1'b1; req = '0; rel = 1'b0;

        // reset with all requesting
        vecs.push_back(mk(1, 16'hFFFF, 0, 16'h0000, 4'd0, 0, 0));
        vecs.push_back(mk(1, 16'hFFFF, 0, 16'h0000, 4'd0, 0, 0));
        vecs.push_back(mk(0, 16'hFFFF, 0, 16'h0001, 4'd0, 1, 0));
        // round robin between 0 and 15, rel in 2nd grant cycle
        vecs.push_back(mk(0, 16'h8001, 0, 16'h0001, 4'd0,  1, 0));
        vecs.push_back(mk(0, 16'h8001, 1, 16'h0000, 4'd0,  0, 0));
        vecs.push_back(mk(0, 16'h8001, 0, 16'h8000, 4'd15, 1, 0));
        vecs.push_back(mk(0, 16'h8001, 0, 16'h8000, 4'd15, 1, 0));
        vecs.push_back(mk(0, 16'h8001, 1, 16'h0000, 4'd15, 0, 0));
        vecs.push_back(mk(0, 16'h8001, 0, 16'h0001, 4'd0,  1, 0));
        vecs.push_back(mk(0, 16'h8001, 0, 16'h0001, 4'd0,  1, 0));
        vecs.push_back(mk(0, 16'h8001, 1, 16'h0000, 4'd0,  0, 0));
        vecs.push_back(mk(0, 16'h8001, 0, 16'h8000, 4'd15, 1, 0));
        vecs.push_back(mk(0, 16'h8001, 0, 16'h8000, 4'd15, 1, 0));
        vecs.push_back(mk(0, 16'h8001, 1, 16'h0000, 4'd15, 0, 0));
        // pointer wrapped to 0
        vecs.push_back(mk(0, 16'h0004, 0, 16'h0004, 4'd2, 1, 0));
        vecs.push_back(mk(0, 16'h0004, 1, 16'h0000, 4'd2, 0, 0));
        // owner 3 drops its request; ptr=4 then skips bit 3
        vecs.push_back(mk(0, 16'h0008, 0, 16'h0008, 4'd3, 1, 0));
        vecs.push_back(mk(0, 16'h0010, 0, 16'h0000, 4'd3, 0, 0));
        vecs.push_back(mk(0, 16'h0018, 0, 16'h0010, 4'd4, 1, 0));
        // rel plus drop on same edge, then rel in IDLE ignored
        vecs.push_back(mk(0, 16'h0000, 1, 16'h0000, 4'd4, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 1, 16'h0000, 4'd4, 0, 0));
        // grant 9, other bits ignored, then reset mid-grant
        vecs.push_back(mk(0, 16'h0200, 0, 16'h0200, 4'd9, 1, 0));
        vecs.push_back(mk(0, 16'h0201, 0, 16'h0200, 4'd9, 1, 0));
        vecs.push_back(mk(1, 16'h0201, 0, 16'h0000, 4'd0, 0, 0));
        vecs.push_back(mk(0, 16'h0201, 0, 16'h0001, 4'd0, 1, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 4'd0, 0, 0));

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].q, vecs[i].l);
            chk("gnt",     gnt,           vecs[i].e_gnt);
            chk("sel",     16'(sel),      16'(vecs[i].e_sel));
            chk("busy",    16'(busy),     16'(vecs[i].e_busy));
            chk("timeout", 16'(timeout),  16'(vecs[i].e_to));
            check_inv();
        end

        // hold limit: ptr=1, requester 5 holds without releasing
        step(0, 16'h0020, 0);
        chk("hl_gnt0", gnt, 16'h0020);
        chk("hl_sel0", 16'(sel), 16'd5);
        check_inv();
        for (int c = 1; c < 4; c++) begin
            step(0, 16'h0020, 0);
            chk("hl_gnt", gnt, 16'h0020);
            chk("hl_to_low", 16'(timeout), 16'h0000);
            check_inv();
        end
        step(0, 16'h0020, 0);
        chk("hl_drop", gnt, 16'h0000);
        chk("hl_busy", 16'(busy), 16'h0000);
        chk("hl_to", 16'(timeout), 16'h0001);
        step(0, 16'h0020, 0);
        chk("hl_regnt", gnt, 16'h0020);
        chk("hl_resel", 16'(sel), 16'd5);
        chk("hl_to_pulse", 16'(timeout), 16'h0000);
        check_inv();
        step(0, 16'h0020, 1);
        chk("hl_relgnt", gnt, 16'h0000);
        chk("hl_rel_to", 16'(timeout), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
